lms_weight_update: RTL and testbench
====================================

LMS_WEIGHT_UPDATE -- requirements
Module: lms_weight_update

Interface
REQ-001 SHALL have parameter N, default 32, number of taps (even, divisible by TPC).
REQ-002 SHALL have parameter TPC, default 2, taps updated per clock.
REQ-003 SHALL have parameters IN_W/ERR_W/COEFF_W, default 32/32/32, and R_IN/R_ERR/R_COEFF, default 31/31/31; these are the widths and fractional bits of the reference, error and coefficient.
REQ-004 SHALL have parameter MU_SHIFT, default 8, step size mu = 2^-MU_SHIFT.
REQ-005 SHALL have port clock, input, 1, single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous, active-low.
REQ-007 SHALL have port valid_in, input, 1, one-cycle strobe marking a new sample pair.
REQ-008 SHALL have port xf_in, input, signed IN_W, filtered-reference sample (Shat-filtered x).
REQ-009 SHALL have port err_in, input, signed ERR_W, error-mic sample.
REQ-010 SHALL have port init_load_en, input, 1, load init_weight into the coefficient bank.
REQ-011 SHALL have port init_weight, input, N x signed COEFF_W unpacked array, initial coefficients.
REQ-012 SHALL have port weight_out, output, N x signed COEFF_W unpacked array, drives W.weight_in directly.
REQ-013 SHALL have port weight_load_en, output, 1, drives W.weight_load_en.
REQ-014 SHALL have port busy, output, 1, high while an update is in progress.
REQ-015 SHALL have port overrun, output, 1, sticky flag for a dropped sample.

Function
REQ-016 SHALL keep history h[0..N-1] of xf samples; h[0] is newest; weight_out[i] pairs with h[i].
REQ-017 SHALL use FSM states IDLE, UPDATE, LOAD.
REQ-018 IDLE, valid_in=1, init_load_en=0: shift xf_in into h[0] (h[i]<=h[i-1], oldest dropped), latch err_in, tap index<=0, go UPDATE.
REQ-019 UPDATE: each cycle update taps index..index+TPC-1, then index+=TPC; after N/TPC cycles go LOAD.
REQ-020 Per tap: p = err*h[i], full width IN_W+ERR_W; d = p >>> (R_IN+R_ERR-R_COEFF+MU_SHIFT), arithmetic (floor).
REQ-021 Per tap: w[i] <= sat(w[i]+d), sum formed at COEFF_W+1 bits or wider, saturating to [-2^(COEFF_W-1), 2^(COEFF_W-1)-1]; no wrap.
REQ-022 LOAD: weight_load_en=1 for exactly one cycle, then go IDLE; weight_out holds the complete updated set during that cycle.
REQ-023 Latency: valid_in sampled at edge t -> weight_load_en high in cycle t+N/TPC+1 (cycle 17 with defaults); busy high from t+1 through the LOAD cycle.
REQ-024 weight_out SHALL change only during UPDATE or on init load; W SHALL see a stable set whenever weight_load_en=1.
REQ-025 valid_in while busy: sample and error discarded, h unchanged, overrun<=1 (sticky until reset).
REQ-026 init_load_en in IDLE: w<=init_weight, next cycle LOAD (one weight_load_en pulse); h unchanged.
REQ-027 init_load_en and valid_in together in IDLE: init wins; sample discarded; overrun not set.
REQ-028 init_load_en while busy: ignored.
REQ-029 weight_load_en SHALL never assert for two consecutive cycles.

Reset
REQ-030 reset=0 at a rising edge SHALL set all w and h to 0, state IDLE, weight_load_en=0, busy=0, overrun=0, index=0.
REQ-031 Reset mid-UPDATE SHALL abort with no weight_load_en pulse; partially updated taps are cleared to 0.
REQ-032 With reset=0, all inputs SHALL be ignored.

Verification
REQ-033 MU_SHIFT=0, w=0, h=0; valid_in with xf=0x40000000, err=0x40000000 -> pulse at t+17; weight_out[0]=0x20000000; all other taps 0.
REQ-034 Init w[3]=0x7FFFFFF0 and h[3]=0x7FFFFFFF (preloaded via 4 samples); positive err=0x7FFFFFFF, MU_SHIFT=0 -> w[3]=0x7FFFFFFF; negative-side mirror -> 0x80000000.
REQ-035 Second valid_in 5 cycles after the first -> second sample dropped; overrun=1; exactly one pulse at t+17; h shows only the first sample.
REQ-036 init_load_en with ramp init_weight[i]=i -> weight_out[i]=i; one weight_load_en pulse next cycle; same-cycle valid_in discarded, overrun=0.
REQ-037 Samples every 32 clocks, defaults, 1000 random pairs -> weights bit-exact vs. fixed-point model; no overrun; one pulse per sample.
REQ-038 reset=0 at UPDATE cycle 8 -> no pulse; all outputs 0 on the next cycle; busy=0.

Source files
------------

// File: rtl/lms_weight_update.sv
// Filtered-x LMS coefficient bank: each new sample pair updates TPC taps per clock, then pulses weight_load_en.
// valid_in at edge t gives the load pulse in cycle t+N/TPC+1; a sample arriving while busy is dropped and sets overrun.
module lms_weight_update #(
   parameter int N        = 32,
   parameter int TPC      = 2,
   parameter int IN_W     = 32,
   parameter int ERR_W    = 32,
   parameter int COEFF_W  = 32,
   parameter int R_IN     = 31,
   parameter int R_ERR    = 31,
   parameter int R_COEFF  = 31,
   parameter int MU_SHIFT = 8
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      valid_in,
   input  logic signed [IN_W-1:0]    xf_in,
   input  logic signed [ERR_W-1:0]   err_in,
   input  logic                      init_load_en,
   input  logic signed [COEFF_W-1:0] init_weight [N],
   output logic signed [COEFF_W-1:0] weight_out [N],
   output logic                      weight_load_en,
   output logic                      busy,
   output logic                      overrun
);

   localparam int PW = IN_W + ERR_W;
   localparam int SW = ((PW > COEFF_W) ? PW : COEFF_W) + 1;
   localparam int SH = R_IN + R_ERR - R_COEFF + MU_SHIFT;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(N - TPC);
   localparam logic [IW-1:0] STEP     = IW'(TPC);
   localparam logic signed [SW-1:0] W_MAX = {{(SW-COEFF_W+1){1'b0}}, {(COEFF_W-1){1'b1}}};
   localparam logic signed [SW-1:0] W_MIN = {{(SW-COEFF_W+1){1'b1}}, {(COEFF_W-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_LOAD} state_t;

   state_t                     state_q;
   logic [IW-1:0]              idx_q;
   logic signed [ERR_W-1:0]    err_q;
   logic signed [IN_W-1:0]     h_q [N];
   logic signed [COEFF_W-1:0]  w_q [N];
   logic                       wld_q;
   logic                       busy_q;
   logic                       ovr_q;

   logic signed [PW-1:0]       err_x;
   logic [IW-1:0]              tap   [TPC];
   logic signed [PW-1:0]       h_x   [TPC];
   logic signed [PW-1:0]       prod  [TPC];
   logic signed [PW-1:0]       dlt   [TPC];
   logic signed [SW-1:0]       sum   [TPC];
   logic signed [COEFF_W-1:0]  upd_d [TPC];

   // Product is exact at PW bits; the sum is one bit wider than either operand so saturation sees the true overflow.
   always_comb begin
      err_x = {{(PW-ERR_W){err_q[ERR_W-1]}}, err_q};
      for (int k = 0; k < TPC; k++) begin
         tap[k]  = idx_q + IW'(k);
         h_x[k]  = {{(PW-IN_W){h_q[tap[k]][IN_W-1]}}, h_q[tap[k]]};
         prod[k] = err_x * h_x[k];
         dlt[k]  = prod[k] >>> SH;
         sum[k]  = {{(SW-PW){dlt[k][PW-1]}}, dlt[k]}
                 + {{(SW-COEFF_W){w_q[tap[k]][COEFF_W-1]}}, w_q[tap[k]]};
         if (sum[k] > W_MAX) begin
            upd_d[k] = W_MAX[COEFF_W-1:0];
         end else if (sum[k] < W_MIN) begin
            upd_d[k] = W_MIN[COEFF_W-1:0];
         end else begin
            upd_d[k] = sum[k][COEFF_W-1:0];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         err_q   <= '0;
         wld_q   <= 1'b0;
         busy_q  <= 1'b0;
         ovr_q   <= 1'b0;
         for (int i = 0; i < N; i++) begin
            h_q[i] <= '0;
            w_q[i] <= '0;
         end
      end else begin
         wld_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (init_load_en) begin
                  for (int i = 0; i < N; i++) w_q[i] <= init_weight[i];
                  state_q <= S_LOAD;
                  wld_q   <= 1'b1;
                  busy_q  <= 1'b1;
               end else if (valid_in) begin
                  h_q[0] <= xf_in;
                  for (int i = 1; i < N; i++) h_q[i] <= h_q[i-1];
                  err_q   <= err_in;
                  idx_q   <= '0;
                  state_q <= S_UPDATE;
                  busy_q  <= 1'b1;
               end
            end
            S_UPDATE: begin
               for (int k = 0; k < TPC; k++) w_q[tap[k]] <= upd_d[k];
               if (idx_q == LAST_IDX) begin
                  state_q <= S_LOAD;
                  wld_q   <= 1'b1;
               end else begin
                  idx_q <= idx_q + STEP;
               end
               if (valid_in) ovr_q <= 1'b1;
            end
            S_LOAD: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               if (valid_in) ovr_q <= 1'b1;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign weight_out     = w_q;
   assign weight_load_en = wld_q;
   assign busy           = busy_q;
   assign overrun        = ovr_q;

endmodule

// File: tb/tb_lms_weight_update.sv
// Bench for lms_weight_update: directed vectors on MU_SHIFT=0 and default instances plus a random run against a reference model.
module tb_lms_weight_update;
   localparam int N = 32;
   localparam longint WMAX = 64'sd2147483647;
   localparam longint WMIN = -64'sd2147483648;

   logic clk = 1'b0;
   logic rst_n, valid, init_en;
   logic signed [31:0] xf, err;
   logic signed [31:0] init_w [N];
   logic signed [31:0] w0_o [N];
   logic signed [31:0] w8_o [N];
   logic wld0, busy0, ovr0, wld8, busy8, ovr8;
   logic wld0_prev = 1'b0, wld8_prev = 1'b0;
   int checks = 0, errors = 0, pulses0 = 0, pulses8 = 0;

   typedef struct {
      logic [31:0] xf;
      logic [31:0] err;
      logic [31:0] exp0;
      logic [31:0] exp8;
   } vec_t;
   vec_t vt [7];

   int w_m0 [N];
   int w_m8 [N];
   int h_m [$];

   always #5 clk = ~clk;

   lms_weight_update #(.MU_SHIFT(0)) dut0 (
      .clock(clk), .reset(rst_n), .valid_in(valid), .xf_in(xf), .err_in(err),
      .init_load_en(init_en), .init_weight(init_w), .weight_out(w0_o),
      .weight_load_en(wld0), .busy(busy0), .overrun(ovr0));

   lms_weight_update dut8 (
      .clock(clk), .reset(rst_n), .valid_in(valid), .xf_in(xf), .err_in(err),
      .init_load_en(init_en), .init_weight(init_w), .weight_out(w8_o),
      .weight_load_en(wld8), .busy(busy8), .overrun(ovr8));

   // The load strobe must never be high on two consecutive cycles.
   always @(negedge clk) begin
      if (wld0) begin
         pulses0++;
         checks++;
         if (wld0_prev) begin
            errors++;
            $display("FAIL dut0 back-to-back load pulse at %0t", $time);
         end
      end
      if (wld8) begin
         pulses8++;
         checks++;
         if (wld8_prev) begin
            errors++;
            $display("FAIL dut8 back-to-back load pulse at %0t", $time);
         end
      end
      wld0_prev = wld0;
      wld8_prev = wld8;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; valid = 1'b0; init_en = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
   endtask

   task automatic send(input logic [31:0] x, input logic [31:0] e);
      xf = x; err = e; valid = 1'b1;
      tick();
      valid = 1'b0;
   endtask

   // Current cycle is t+start; advance until the load pulse or the bound.
   task automatic wait_pulse(input int start, output int cyc);
      cyc = start;
      while (!wld0 && cyc < 40) begin
         tick();
         cyc++;
      end
   endtask

   function automatic int model_upd(input int w, input int hv, input int e, input int sh);
      longint p, d, s;
      p = longint'(e) * longint'(hv);
      d = p >>> (31 + sh);
      s = longint'(w) + d;
      if (s > WMAX) s = WMAX;
      else if (s < WMIN) s = WMIN;
      return int'(s);
   endfunction

   task automatic sat_case(input string name, input logic [31:0] init3, input logic [31:0] e,
                           input logic [31:0] exp);
      int cyc;
      do_reset();
      send(32'h7FFFFFFF, 32'h0); wait_pulse(1, cyc); tick();
      send(32'h0, 32'h0);        wait_pulse(1, cyc); tick();
      send(32'h0, 32'h0);        wait_pulse(1, cyc); tick();
      for (int i = 0; i < N; i++) init_w[i] = 32'h0;
      init_w[3] = init3;
      init_en = 1'b1;
      tick();
      init_en = 1'b0;
      check({name, " init w3"}, w0_o[3], init3);
      tick();
      send(32'h0, e);
      wait_pulse(1, cyc);
      check({name, " w3"}, w0_o[3], exp);
      check({name, " w0"}, w0_o[0], 32'h0);
      check({name, " overrun"}, {31'b0, ovr0}, 32'h0);
   endtask

   initial begin
      int cyc, p0, p8, bad0, bad8, sel;
      logic [31:0] rx, re;

      vt[0] = '{32'h40000000, 32'h40000000, 32'h20000000, 32'h00200000};
      vt[1] = '{32'h40000000, 32'hC0000000, 32'hE0000000, 32'hFFE00000};
      vt[2] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFE, 32'h007FFFFF};
      vt[3] = '{32'h80000000, 32'h80000000, 32'h7FFFFFFF, 32'h00800000};
      vt[4] = '{32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
      vt[5] = '{32'h00000001, 32'h00000001, 32'h00000000, 32'h00000000};
      vt[6] = '{32'h80000000, 32'h7FFFFFFF, 32'h80000001, 32'hFF800000};

      // Inputs are ignored while reset is held.
      rst_n = 1'b0; xf = 32'h40000000; err = 32'h40000000; valid = 1'b1; init_en = 1'b1;
      for (int i = 0; i < N; i++) init_w[i] = i;
      tick(); tick(); tick();
      check("reset w5", w0_o[5], 32'h0);
      check("reset busy", {31'b0, busy0}, 32'h0);
      check("reset wld", {31'b0, wld0}, 32'h0);
      check("reset overrun", {31'b0, ovr0}, 32'h0);
      valid = 1'b0; init_en = 1'b0;
      rst_n = 1'b1;
      tick();
      check("idle w5", w0_o[5], 32'h0);

      foreach (vt[v]) begin
         do_reset();
         send(vt[v].xf, vt[v].err);
         check($sformatf("vec%0d busy", v), {31'b0, busy0}, 32'h1);
         wait_pulse(1, cyc);
         check($sformatf("vec%0d latency", v), cyc, 17);
         check($sformatf("vec%0d dut0 w0", v), w0_o[0], vt[v].exp0);
         check($sformatf("vec%0d dut8 w0", v), w8_o[0], vt[v].exp8);
         check($sformatf("vec%0d dut0 w1", v), w0_o[1], 32'h0);
         tick();
         check($sformatf("vec%0d wld after", v), {31'b0, wld0}, 32'h0);
         check($sformatf("vec%0d busy after", v), {31'b0, busy0}, 32'h0);
      end

      sat_case("sat pos", 32'h7FFFFFF0, 32'h7FFFFFFF, 32'h7FFFFFFF);
      sat_case("sat neg", 32'h80000010, 32'h80000000, 32'h80000000);

      // Init load with a simultaneous sample: init wins, sample discarded.
      do_reset();
      for (int i = 0; i < N; i++) init_w[i] = i;
      xf = 32'h40000000; err = 32'h40000000; valid = 1'b1; init_en = 1'b1;
      tick();
      valid = 1'b0; init_en = 1'b0;
      check("init wld", {31'b0, wld0}, 32'h1);
      bad0 = 0;
      for (int i = 0; i < N; i++) if (w0_o[i] !== i && bad0 == 0) bad0 = i;
      check($sformatf("init ramp tap%0d", bad0), w0_o[bad0], bad0);
      check("init overrun", {31'b0, ovr0}, 32'h0);
      tick();
      check("init wld single", {31'b0, wld0}, 32'h0);
      send(32'h0, 32'h40000000);
      wait_pulse(1, cyc);
      check("init discard w1", w0_o[1], 32'h1);
      check("init discard w0", w0_o[0], 32'h0);
      tick();

      // Reset at UPDATE cycle 8 aborts with no pulse.
      send(32'h40000000, 32'h40000000);
      for (int i = 0; i < 7; i++) tick();
      p0 = pulses0;
      rst_n = 1'b0;
      tick();
      bad0 = 0;
      for (int i = 0; i < N; i++) if (w0_o[i] !== 0 && bad0 == 0) bad0 = i;
      check($sformatf("abort w tap%0d", bad0), w0_o[bad0], 32'h0);
      check("abort busy", {31'b0, busy0}, 32'h0);
      check("abort wld", {31'b0, wld0}, 32'h0);
      rst_n = 1'b1;
      for (int i = 0; i < 30; i++) tick();
      check("abort no pulse", pulses0 - p0, 0);

      // Second sample 5 cycles after the first is dropped; init while busy ignored.
      do_reset();
      p0 = pulses0;
      send(32'h40000000, 32'h40000000);
      for (int i = 0; i < 4; i++) tick();
      xf = 32'h7FFFFFFF; err = 32'h7FFFFFFF; valid = 1'b1; init_en = 1'b1;
      tick();
      valid = 1'b0; init_en = 1'b0;
      check("ovr flag", {31'b0, ovr0}, 32'h1);
      wait_pulse(6, cyc);
      check("ovr latency", cyc, 17);
      check("ovr w0", w0_o[0], 32'h20000000);
      check("ovr w1", w0_o[1], 32'h0);
      for (int i = 0; i < 20; i++) tick();
      check("ovr one pulse", pulses0 - p0, 1);
      send(32'h0, 32'h40000000);
      wait_pulse(1, cyc);
      check("ovr hist w1", w0_o[1], 32'h20000000);
      check("ovr hist w2", w0_o[2], 32'h0);
      check("ovr sticky", {31'b0, ovr0}, 32'h1);
      tick();

      // Random samples every 32 clocks against the model.
      do_reset();
      h_m = {};
      for (int i = 0; i < N; i++) begin
         h_m.push_back(0);
         w_m0[i] = 0;
         w_m8[i] = 0;
      end
      p0 = pulses0; p8 = pulses8;
      for (int s = 0; s < 1000; s++) begin
         sel = $urandom_range(0, 9);
         rx = (sel == 0) ? 32'h7FFFFFFF : (sel == 1) ? 32'h80000000 : $urandom;
         re = (sel == 2) ? 32'h80000000 : $urandom;
         h_m.push_front(int'(rx));
         void'(h_m.pop_back());
         for (int i = 0; i < N; i++) begin
            w_m0[i] = model_upd(w_m0[i], h_m[i], int'(re), 0);
            w_m8[i] = model_upd(w_m8[i], h_m[i], int'(re), 8);
         end
         send(rx, re);
         wait_pulse(1, cyc);
         if (cyc != 17) check($sformatf("rand s%0d latency", s), cyc, 17);
         bad0 = 0; bad8 = 0;
         for (int i = N - 1; i >= 0; i--) begin
            if (w0_o[i] !== w_m0[i]) bad0 = i;
            if (w8_o[i] !== w_m8[i]) bad8 = i;
         end
         check($sformatf("rand s%0d dut0 tap%0d", s, bad0), w0_o[bad0], w_m0[bad0]);
         check($sformatf("rand s%0d dut8 tap%0d", s, bad8), w8_o[bad8], w_m8[bad8]);
         for (int i = 0; i < 15; i++) tick();
      end
      check("rand overrun0", {31'b0, ovr0}, 32'h0);
      check("rand overrun8", {31'b0, ovr8}, 32'h0);
      check("rand pulses0", pulses0 - p0, 1000);
      check("rand pulses8", pulses8 - p8, 1000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
